// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered lane-parallel half adder.
// Selector encodings for the per-lane case decode, pipeline depth limit,
// statistics counter width and its saturating increment helper.
package half_adder_pkg;

   // {a,b} selector encodings used by the truth-table decode
   localparam logic [1:0] OP_00 = 2'b00;
   localparam logic [1:0] OP_01 = 2'b01;
   localparam logic [1:0] OP_10 = 2'b10;
   localparam logic [1:0] OP_11 = 2'b11;

   // Deepest operand-to-output pipeline supported
   localparam int PIPE_STAGES_MAX = 4;

   // Width of the optional carry statistics counter
   localparam int CARRY_CNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CARRY_CNT_W-1:0] sat_inc(input logic [CARRY_CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder decoded from an explicit truth table.
// Operands that are not a clean 0/1 pair fall to the default arm and give
// s=0, c=0, so an unknown operand never turns into an unknown result.
module half_adder_cell
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Truth-table decode of {a,b} into sum and carry
   always_comb begin
      // NOTE: every output gets a value before the case so no path can leave it unassigned and infer a latch.
      s = 1'b0;
      c = 1'b0;
      case ({a, b})
         OP_00: begin s = 1'b0; c = 1'b0; end
         OP_01: begin s = 1'b1; c = 1'b0; end
         OP_10: begin s = 1'b1; c = 1'b0; end
         OP_11: begin s = 1'b0; c = 1'b1; end
         default: begin s = 1'b0; c = 1'b0; end
      endcase
   end

endmodule

// File: rtl/half_adder_beh_case.sv
// Registered, lane-parallel half adder.
// WIDTH independent lanes are decoded combinationally by half_adder_cell and
// then carried through PIPE_STAGES register stages alongside a valid bit.
// Data registers only load when their input is valid, so S/C hold the last
// result across bubbles. Reset is synchronous and active-high.
// Optional build macro HALF_ADDER_STATS_EN adds carry_count, a saturating
// count of valid results that carry in any lane.
module half_adder_beh_case
   import half_adder_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int PIPE_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] C
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [CARRY_CNT_W-1:0] carry_count
`endif
);

   // Depth actually built; out-of-range settings are pinned to the legal range
   localparam int STAGES = (PIPE_STAGES < 1) ? 1 :
                           (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX : PIPE_STAGES;

   logic [WIDTH-1:0]  dec_s;
   logic [WIDTH-1:0]  dec_c;
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  c_q [STAGES];

   // One decode cell per lane; lanes never share carries
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a (A[i]),
         .b (B[i]),
         .s (dec_s[i]),
         .c (dec_c[i])
      );
   end

   // Valid/data pipeline: valid always shifts, data only moves with a valid bit
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         // NOTE: the data stages are cleared too, not just the valid bits, so S/C read 0 right after reset instead of a stale result.
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates let every stage read its neighbour's old value, which is what makes this a shift and not a fall-through.
         vld_q[0] <= in_valid;
         if (in_valid) begin
            s_q[0] <= dec_s;
            c_q[0] <= dec_c;
         end
         for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               s_q[k] <= s_q[k-1];
               c_q[k] <= c_q[k-1];
            end
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign S         = s_q[STAGES-1];
   assign C         = c_q[STAGES-1];

`ifdef HALF_ADDER_STATS_EN
   // Signals entering the final stage, so the count moves on the same edge as the result
   logic             last_in_vld;
   logic [WIDTH-1:0] last_in_c;

   if (STAGES == 1) begin : g_last_single
      assign last_in_vld = in_valid;
      assign last_in_c   = dec_c;
   end else begin : g_last_multi
      assign last_in_vld = vld_q[STAGES-2];
      assign last_in_c   = c_q[STAGES-2];
   end

   // Saturating count of valid results with a carry in any lane
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_count <= '0;
      end else if (last_in_vld && (|last_in_c)) begin
         carry_count <= sat_inc(carry_count);
      end
   end
`endif

endmodule

// File: tb/tb_half_adder_beh_case.sv
// Self-checking bench for half_adder_beh_case.
// Two instances run from the same stimulus: the default single-lane,
// single-stage build and a 4-lane, 3-stage build. A history-based model
// derives every expected output from the recorded input samples.
// Build with HALF_ADDER_STATS_EN defined to also check carry_count.
module tb_half_adder_beh_case;
   import half_adder_pkg::*;

   localparam int MAXC = 2048;
   localparam int P1   = 1;
   localparam int P4   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] a_in = '0;
   logic [3:0] b_in = '0;

   logic       v1;
   logic [0:0] s1, c1;
   logic       v4;
   logic [3:0] s4, c4;
`ifdef HALF_ADDER_STATS_EN
   logic [CARRY_CNT_W-1:0] cc1, cc4;
`endif

   int total = 0;
   int bad   = 0;

   // Recorded input samples, one entry per rising edge
   logic       r_h [MAXC];
   logic       v_h [MAXC];
   logic [3:0] a_h [MAXC];
   logic [3:0] b_h [MAXC];
   int         n_edges = 0;

   always #5 clk = ~clk;

   half_adder_beh_case #(.WIDTH(1), .PIPE_STAGES(P1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (a_in[0:0]),
      .B         (b_in[0:0]),
      .out_valid (v1),
      .S         (s1),
      .C         (c1)
`ifdef HALF_ADDER_STATS_EN
      ,
      .carry_count (cc1)
`endif
   );

   half_adder_beh_case #(.WIDTH(4), .PIPE_STAGES(P4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (a_in),
      .B         (b_in),
      .out_valid (v4),
      .S         (s4),
      .C         (c4)
`ifdef HALF_ADDER_STATS_EN
      ,
      .carry_count (cc4)
`endif
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Record what the DUTs sample on each rising edge
   always @(posedge clk) begin
      if (n_edges < MAXC) begin
         r_h[n_edges] <= rst;
         v_h[n_edges] <= in_valid;
         a_h[n_edges] <= a_in;
         b_h[n_edges] <= b_in;
      end
      n_edges <= n_edges + 1;
   end

   // Expected output after edge n for a pipeline of depth p: the sample taken
   // p-1 edges earlier, valid only if no reset was sampled since then.
   function automatic void exp_at(input int n, input int p, output logic v,
                                  output logic [3:0] s, output logic [3:0] c);
      int idx;
      idx = n - p + 1;
      v = 1'b0;
      s = '0;
      c = '0;
      if (idx >= 0) begin
         v = v_h[idx];
         for (int j = idx; j <= n; j++) if (r_h[j]) v = 1'b0;
         for (int l = 0; l < 4; l++) begin
            if ($isunknown({a_h[idx][l], b_h[idx][l]})) begin
               s[l] = 1'b0;
               c[l] = 1'b0;
            end else begin
               s[l] = a_h[idx][l] ^ b_h[idx][l];
               c[l] = a_h[idx][l] & b_h[idx][l];
            end
         end
      end
   endfunction

   // Model state: held outputs and carry counts per instance
   logic [3:0] h_s1 = '0, h_c1 = '0, h_s4 = '0, h_c4 = '0;
   int         m_cc1 = 0, m_cc4 = 0;

   // Compare both instances against the model every cycle
   always @(negedge clk) begin
      logic       e_v1, e_v4;
      logic [3:0] e_s1, e_c1, e_s4, e_c4;
      int         n;
      if (n_edges > 0 && n_edges <= MAXC) begin
         n = n_edges - 1;
         exp_at(n, P1, e_v1, e_s1, e_c1);
         exp_at(n, P4, e_v4, e_s4, e_c4);
         e_s1 = e_s1 & 4'b0001;
         e_c1 = e_c1 & 4'b0001;
         if (e_v1) begin h_s1 = e_s1; h_c1 = e_c1; end
         else if (r_h[n]) begin h_s1 = '0; h_c1 = '0; end
         if (e_v4) begin h_s4 = e_s4; h_c4 = e_c4; end
         else if (r_h[n]) begin h_s4 = '0; h_c4 = '0; end
         if (r_h[n]) m_cc1 = 0;
         else if (e_v1 && (|e_c1) && m_cc1 < 65535) m_cc1++;
         if (r_h[n]) m_cc4 = 0;
         else if (e_v4 && (|e_c4) && m_cc4 < 65535) m_cc4++;

         check("d1_valid", {63'd0, v1}, {63'd0, e_v1});
         check("d1_sum",   {63'd0, s1}, {60'd0, h_s1});
         check("d1_carry", {63'd0, c1}, {60'd0, h_c1});
         check("d4_valid", {63'd0, v4}, {63'd0, e_v4});
         check("d4_sum",   {60'd0, s4}, {60'd0, h_s4});
         check("d4_carry", {60'd0, c4}, {60'd0, h_c4});
         check("d4_s_and_c", {60'd0, s4 & c4}, 64'd0);
`ifdef HALF_ADDER_STATS_EN
         check("d1_count", {48'd0, cc1}, 64'(m_cc1));
         check("d4_count", {48'd0, cc4}, 64'(m_cc4));
`endif
      end
   end

   // Apply one cycle of inputs and return just after the sampling edge
   task automatic cyc_drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a_in     = a;
      b_in     = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] tbl_s;
      logic [3:0] tbl_c;
      logic [1:0] ab;
      tbl_s = 4'b0110;
      tbl_c = 4'b1000;

      // Reset state
      cyc_drive(1'b1, 1'b0, 4'h0, 4'h0);
      cyc_drive(1'b1, 1'b0, 4'h0, 4'h0);
      check("lit_rst_v1", {63'd0, v1}, 64'd0);
      check("lit_rst_s1", {63'd0, s1}, 64'd0);
      check("lit_rst_c1", {63'd0, c1}, 64'd0);
      check("lit_rst_v4", {63'd0, v4}, 64'd0);

      // Exhaustive single-lane truth table
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         cyc_drive(1'b0, 1'b1, {4{ab[1]}}, {4{ab[0]}});
         check("lit_tt_v", {63'd0, v1}, 64'd1);
         check("lit_tt_s", {63'd0, s1}, {63'd0, tbl_s[i]});
         check("lit_tt_c", {63'd0, c1}, {63'd0, tbl_c[i]});
      end

      // Reset with a live 11 operand: nothing emerges
      cyc_drive(1'b1, 1'b1, 4'hF, 4'hF);
      check("lit_rr_v", {63'd0, v1}, 64'd0);
      check("lit_rr_c", {63'd0, c1}, 64'd0);
      cyc_drive(1'b1, 1'b1, 4'hF, 4'hF);
      check("lit_rr_v2", {63'd0, v1}, 64'd0);
      cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);
      check("lit_rr_after_v", {63'd0, v1}, 64'd0);
      check("lit_rr_after_s", {63'd0, s1}, 64'd0);
      check("lit_rr_after_c", {63'd0, c1}, 64'd0);

      // Bubble in the middle: S/C hold across it
      cyc_drive(1'b0, 1'b1, 4'hF, 4'hF);
      check("lit_bub1_v", {63'd0, v1}, 64'd1);
      check("lit_bub1_c", {63'd0, c1}, 64'd1);
      cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);
      check("lit_bub2_v", {63'd0, v1}, 64'd0);
      check("lit_bub2_s", {63'd0, s1}, 64'd0);
      check("lit_bub2_c", {63'd0, c1}, 64'd1);
      cyc_drive(1'b0, 1'b1, 4'h0, 4'hF);
      check("lit_bub3_v", {63'd0, v1}, 64'd1);
      check("lit_bub3_s", {63'd0, s1}, 64'd1);
      check("lit_bub3_c", {63'd0, c1}, 64'd0);

      // Multi-lane, three-stage latency
      cyc_drive(1'b0, 1'b1, 4'b1100, 4'b1010);
      check("lit_ml_early", {63'd0, v4}, 64'd0);
      cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);
      cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);
      check("lit_ml_v", {63'd0, v4}, 64'd1);
      check("lit_ml_s", {60'd0, s4}, 64'b0110);
      check("lit_ml_c", {60'd0, c4}, 64'b1000);

      // Unknown operand: valid result that never has both S and C set
      cyc_drive(1'b0, 1'b1, 4'bxxxx, 4'b1111);
      check("lit_x_v", {63'd0, v1}, 64'd1);
      check("lit_x_sc", {63'd0, s1 & c1}, 64'd0);

      // Carry statistics: five results, three with a carry
      cyc_drive(1'b1, 1'b0, 4'h0, 4'h0);
      cyc_drive(1'b0, 1'b1, 4'hF, 4'hF);
      cyc_drive(1'b0, 1'b1, 4'h0, 4'hF);
      cyc_drive(1'b0, 1'b1, 4'hF, 4'hF);
      cyc_drive(1'b0, 1'b1, 4'h0, 4'h0);
      cyc_drive(1'b0, 1'b1, 4'hF, 4'hF);
      for (int i = 0; i < 3; i++) cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);
`ifdef HALF_ADDER_STATS_EN
      check("lit_cc1", {48'd0, cc1}, 64'd3);
      check("lit_cc4", {48'd0, cc4}, 64'd3);
`endif
      cyc_drive(1'b1, 1'b0, 4'h0, 4'h0);
`ifdef HALF_ADDER_STATS_EN
      check("lit_cc1_rst", {48'd0, cc1}, 64'd0);
      check("lit_cc4_rst", {48'd0, cc4}, 64'd0);
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         cyc_drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                   4'($urandom), 4'($urandom));
      end
      for (int i = 0; i < 5; i++) cyc_drive(1'b0, 1'b0, 4'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
